// File: rtl/dmem_resp_if.sv
// -----------------------------------------------------------------------------
// dmem_resp_if
//   Request/response bundle between the execute stage and the data-memory
//   responder.
//
//   Request (master -> slave):
//     cs_i        request strobe
//     mem_we_i    1 = write, 0 = read
//     mem_wem_i   byte-lane write enables, bit k covers mem_din_i[8k+7:8k]
//     mem_din_i   write data
//     mem_addr_i  byte address (word index = addr[31:2])
//   Response (slave -> master):
//     req_rdy_o   request can be accepted this cycle
//     rsp_vld_o   one-cycle response pulse
//     rsp_data_o  read data (0 for writes and errors)
//     rsp_err_o   access error, valid with rsp_vld_o
//     hold_o      stall request to ctrl
// -----------------------------------------------------------------------------
interface dmem_resp_if;
    logic        cs_i;
    logic        mem_we_i;
    logic [3:0]  mem_wem_i;
    logic [31:0] mem_din_i;
    logic [31:0] mem_addr_i;
    logic        req_rdy_o;
    logic        rsp_vld_o;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;
    logic        hold_o;

    modport master (
        output cs_i, mem_we_i, mem_wem_i, mem_din_i, mem_addr_i,
        input  req_rdy_o, rsp_vld_o, rsp_data_o, rsp_err_o, hold_o
    );

    modport slave (
        input  cs_i, mem_we_i, mem_wem_i, mem_din_i, mem_addr_i,
        output req_rdy_o, rsp_vld_o, rsp_data_o, rsp_err_o, hold_o
    );
endinterface

// File: rtl/dmem_resp.sv
// -----------------------------------------------------------------------------
// dmem_resp
//   Data-memory responder. Accepts one request at a time, waits WAIT_CYCLES
//   cycles, then performs a byte-masked write or a full-word read on an
//   internal synchronous word array and returns a one-cycle response pulse.
//   hold_o stalls the pipeline while an access is outstanding.
//
//   Ports:
//     clk   system clock, rising edge
//     rst   asynchronous, active-high reset
//     bus   dmem_resp_if.slave (request in, response/hold out)
//
//   Parameters:
//     DEPTH_WORDS  words in the array (power of two, 16..65536)
//     WAIT_CYCLES  wait states between accept and response (0..7)
//
//   Optional feature (macro DMEM_ERR_EN):
//     defined   - word index >= DEPTH_WORDS returns rsp_err_o = 1, data 0,
//                 and the write is suppressed
//     undefined - the word index wraps modulo DEPTH_WORDS, rsp_err_o = 0
// -----------------------------------------------------------------------------
module dmem_resp #(
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    dmem_resp_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [2:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 3'd0 : 3'(WAIT_CYCLES - 1);

    logic [1:0]       state;
    logic [2:0]       wait_cnt;

    // Request captured at accept; only these are used while in WAIT.
    logic             cap_we;
    logic [3:0]       cap_wem;
    logic [31:0]      cap_din;
    logic [IDX_W-1:0] cap_idx;
    logic             cap_err;

    logic             rsp_vld;
    logic [31:0]      rsp_data;
    logic             rsp_err;

    logic [31:0]      mem [DEPTH_WORDS];

    logic             req_rdy;
    logic             accept;
    logic             enter_resp;
    logic [IDX_W-1:0] in_idx;
    logic             in_err;

    // Operands of the array access on the edge entering RESP.
    logic             acc_we;
    logic [3:0]       acc_wem;
    logic [31:0]      acc_din;
    logic [IDX_W-1:0] acc_idx;
    logic             acc_err;
    logic             wr_en;

    assign req_rdy = (state != ST_WAIT);
    assign accept  = bus.cs_i & req_rdy;
    assign in_idx  = bus.mem_addr_i[IDX_W+1:2];

`ifdef DMEM_ERR_EN
    logic unused_addr_bits;
    assign in_err           = |bus.mem_addr_i[31:IDX_W+2];
    assign unused_addr_bits = ^bus.mem_addr_i[1:0];
`else
    // Upper address bits are dropped so the index wraps modulo DEPTH_WORDS.
    logic unused_addr_bits;
    assign in_err           = 1'b0;
    assign unused_addr_bits = ^{bus.mem_addr_i[31:IDX_W+2], bus.mem_addr_i[1:0], cap_err};
`endif

    // With zero wait states the array is accessed on the accept edge itself,
    // so the live inputs are used; otherwise the captured request is used.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        acc_we  = bus.mem_we_i;
        acc_wem = bus.mem_wem_i;
        acc_din = bus.mem_din_i;
        acc_idx = in_idx;
        acc_err = in_err;
        if (state == ST_WAIT) begin
            acc_we  = cap_we;
            acc_wem = cap_wem;
            acc_din = cap_din;
            acc_idx = cap_idx;
            acc_err = cap_err;
        end
    end

    assign enter_resp = ((state == ST_WAIT) && (wait_cnt == 3'd0)) ||
                        (accept && (WAIT_CYCLES == 0));

    // rst gate keeps a request strobed during reset from touching the array.
    assign wr_en = enter_resp & acc_we & ~acc_err & ~rst;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            wait_cnt <= 3'd0;
            cap_we   <= 1'b0;
            cap_wem  <= 4'd0;
            cap_din  <= 32'd0;
            cap_idx  <= '0;
            cap_err  <= 1'b0;
            rsp_vld  <= 1'b0;
            rsp_data <= 32'd0;
            rsp_err  <= 1'b0;
        end else begin
            if (accept) begin
                cap_we  <= bus.mem_we_i;
                cap_wem <= bus.mem_wem_i;
                cap_din <= bus.mem_din_i;
                cap_idx <= in_idx;
                cap_err <= in_err;
            end

            case (state)
                ST_IDLE, ST_RESP: begin
                    if (!accept) begin
                        state <= ST_IDLE;
                    end else if (WAIT_CYCLES == 0) begin
                        state <= ST_RESP;
                    end else begin
                        state    <= ST_WAIT;
                        wait_cnt <= WAIT_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        state <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Response flags are live only for the RESP cycle; data holds otherwise.
            rsp_vld <= enter_resp;
            rsp_err <= enter_resp & acc_err;
            if (enter_resp) begin
                rsp_data <= (acc_we || acc_err) ? 32'd0 : mem[acc_idx];
            end
        end
    end

    // NOTE: the array is deliberately not reset; contents survive rst and map to plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (acc_wem[k]) begin
                    mem[acc_idx][8*k +: 8] <= acc_din[8*k +: 8];
                end
            end
        end
    end

    assign bus.req_rdy_o  = req_rdy;
    assign bus.rsp_vld_o  = rsp_vld;
    assign bus.rsp_data_o = rsp_data;
    assign bus.rsp_err_o  = rsp_err;
    assign bus.hold_o     = (state == ST_WAIT) | (bus.cs_i & ~req_rdy);

endmodule
